dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
// Sequences every load/store of the M stage onto the data bus: issues one request, holds it until ack,
//   then returns aligned, sign/zero-extended load data (the lOut source for the M-stage writeback select).
// Stalls the pipeline while a transfer is outstanding. Raises AdEL/AdES/DBE exceptions.
// Suppresses writeback when the exception request (req) flushes the stage.
// PARAMETERS
// TIMEOUT_CYC  256  cycles in WAIT without bus_ack before DBE is raised (>=2)
// CNT_W        8    width of timeout counter; must satisfy 2**CNT_W >= TIMEOUT_CYC
// PORTS
// clk         in   1   pipeline clock
// reset       in   1   asynchronous, active-low reset
// mem_rd      in   1   M-stage instruction is a load (lw/lh/lhu/lb/lbu)
// mem_wr      in   1   M-stage instruction is a store (sw/sh/sb)
// mem_size    in   2   0=byte 1=half 2=word (3 reserved; treated as word)
// mem_sign    in   1   load sign-extends (lb/lh)
// addr        in   32  effective address
// wdata       in   32  store data, low-aligned
// req         in   1   exception/interrupt flush of M stage
// bus_req     out  1   bus request, held until bus_ack
// bus_we      out  1   write enable
// bus_addr    out  32  word address {addr[31:2],2'b00}
// bus_be      out  4   byte enables
// bus_wdata   out  32  lane-replicated store data
// bus_ack     in   1   transfer complete (one cycle)
// bus_rdata   in   32  read word, valid with bus_ack
// stall       out  1   freeze F/D/E/M stages
// load_valid  out  1   load_data valid for writeback this cycle
// load_data   out  32  aligned, extended load result
// exc_valid   out  1   exception raised this cycle
// exc_code    out  4   4=AdEL 5=AdES 7=DBE
// BEHAVIOUR
// Reset (reset=0, any time, asynchronous): state=IDLE, all outputs 0, counter 0; in-flight op is dropped.
// States: IDLE -> WAIT -> RESP -> IDLE.
// IDLE: op = (mem_rd|mem_wr) & !req.
//   - Misaligned (half & addr[0], word & addr[1:0]!=0): exc_valid=1 for one cycle
//     (code 4 load / 5 store), no bus activity, stay IDLE.
//   - Aligned op: register bus_req/bus_we/bus_addr/bus_be/bus_wdata, go WAIT; stall=1 combinationally this cycle.
//   - mem_rd&mem_wr both set: treated as load.
// WAIT: bus_* outputs held stable; stall=1; counter increments each cycle.
//   - bus_ack: capture bus_rdata, drop bus_req, go RESP.
//   - Counter reaches TIMEOUT_CYC-1 without ack: drop bus_req, exc_valid=1 code 7, go IDLE, stall=0.
//   - req during WAIT: bus transfer still completes (no abort), but a sticky kill bit blocks load_valid in RESP.
// RESP: stall=0; load_valid=1 for a load not killed (stores: load_valid=0); go IDLE.
//   - Pipeline advances on this edge, so the next op is seen in IDLE on the following cycle (min 3 cycles/access).
// Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'b1111.
// Store data: byte replicated x4, half replicated x2, word as-is.
// Load extract: select lane by addr[1:0]/addr[1]; extend bit 7/15 if mem_sign else zero.
// exc_valid and load_valid are never both 1; exc_valid is one cycle wide.
// bus_ack outside WAIT is ignored.
// STRUCTURE
// Shared define.v gains: state encodings (`DMC_IDLE/`DMC_WAIT/`DMC_RESP),
//   size codes (`SZ_B/`SZ_H/`SZ_W), exception codes (`EXC_ADEL=4, `EXC_ADES=5, `EXC_DBE=7).
// Sub-module: load_align (combinational: rdata, addr[1:0], size, sign -> load_data);
//   the FSM, counter and bus registers stay in this module.
// TESTING
// lw addr=0x100, ack after 2 cycles, rdata=0xDEADBEEF -> bus_be=4'hF, stall 3 cycles, load_valid with 0xDEADBEEF.
// lb addr=0x103 sign, rdata=0x80xxxxxx -> bus_be=4'b1000, load_data=0xFFFFFF80; same with lbu -> 0x00000080.
// sh addr=0x202 wdata=0x1234 -> bus_be=4'b1100, bus_wdata=0x12341234, bus_we=1, load_valid stays 0.
// lw addr=0x101 -> exc_valid=1 code 4, bus_req never rises; sh addr=0x3 -> code 5.
// lw, no ack for TIMEOUT_CYC cycles -> exc_valid=1 code 7, bus_req drops, stall drops.
// lw with req pulsed in WAIT -> ack still consumed, load_valid=0.
// Reset asserted in WAIT -> all outputs 0 immediately; next lw proceeds normally.

Source files
------------

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared encodings for the M-stage data-memory controller: FSM states, access
// sizes, exception codes and the byte-lane helpers used on the store path.
package dmem_access_ctrl_pkg;

    localparam logic [1:0] DMC_IDLE = 2'd0;
    localparam logic [1:0] DMC_WAIT = 2'd1;
    localparam logic [1:0] DMC_RESP = 2'd2;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [3:0] EXC_ADEL = 4'd4;
    localparam logic [3:0] EXC_ADES = 4'd5;
    localparam logic [3:0] EXC_DBE  = 4'd7;

    // Size code 3 is reserved and behaves like a word everywhere.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return addrLo[0];
            default: return |addrLo;
        endcase
    endfunction

    function automatic logic [3:0] byteEnable(input logic [1:0] size, input logic [1:0] addrLo);
        case (size)
            SZ_B:    return 4'b0001 << addrLo;
            SZ_H:    return 4'b0011 << {addrLo[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] laneData(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_B:    return {4{wdata[7:0]}};
            SZ_H:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_load_align.sv
// Picks the addressed byte/half lane out of a bus read word and sign- or
// zero-extends it into a 32-bit load result.
module load_align
    import dmem_access_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addrLo,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] loadData
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    assign byteLane = rdata[{addrLo, 3'b000} +: 8];
    assign halfLane = addrLo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        case (size)
            SZ_B:    loadData = {{24{sign & byteLane[7]}}, byteLane};
            SZ_H:    loadData = {{16{sign & halfLane[15]}}, halfLane};
            default: loadData = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// M-stage load/store sequencer: one bus request per access, held until ack,
// with pipeline stall, address/bus-error exceptions and flush-aware writeback.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 256,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [1:0]  mem_size,
    input  logic        mem_sign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        req,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        exc_valid,
    output logic [3:0]  exc_code
);

    logic [1:0]       state;
    logic [CNT_W-1:0] waitCnt;
    logic             isLoadR;
    logic [1:0]       sizeR;
    logic             signR;
    logic [1:0]       addrLoR;
    logic             killR;
    logic [31:0]      rdataR;

    logic opReq;
    logic misaligned;
    logic startOp;
    logic timeoutHit;

    assign opReq      = (mem_rd | mem_wr) & ~req;
    assign misaligned = isMisaligned(mem_size, addr[1:0]);
    assign startOp    = (state == DMC_IDLE) & opReq & ~misaligned;
    assign timeoutHit = (state == DMC_WAIT) & ~bus_ack
                      & (waitCnt == CNT_W'(TIMEOUT_CYC - 1));

    // Combinational outputs are masked by reset so they read 0 the moment reset asserts.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        stall      = 1'b0;
        exc_valid  = 1'b0;
        exc_code   = 4'd0;
        load_valid = 1'b0;
        if (reset) begin
            case (state)
                DMC_IDLE: begin
                    if (opReq && misaligned) begin
                        exc_valid = 1'b1;
                        exc_code  = mem_rd ? EXC_ADEL : EXC_ADES;
                    end else if (opReq) begin
                        stall = 1'b1;
                    end
                end
                DMC_WAIT: begin
                    if (timeoutHit) begin
                        exc_valid = 1'b1;
                        exc_code  = EXC_DBE;
                    end else begin
                        stall = 1'b1;
                    end
                end
                DMC_RESP: load_valid = isLoadR & ~killR & ~req;
                default: ;
            endcase
        end
    end

    // NOTE: state and bus registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= DMC_IDLE;
            waitCnt   <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            isLoadR   <= 1'b0;
            sizeR     <= SZ_B;
            signR     <= 1'b0;
            addrLoR   <= '0;
            killR     <= 1'b0;
            rdataR    <= '0;
        end else begin
            case (state)
                DMC_IDLE: begin
                    if (startOp) begin
                        state     <= DMC_WAIT;
                        waitCnt   <= '0;
                        bus_req   <= 1'b1;
                        bus_we    <= ~mem_rd;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_be    <= byteEnable(mem_size, addr[1:0]);
                        bus_wdata <= laneData(mem_size, wdata);
                        isLoadR   <= mem_rd;
                        sizeR     <= mem_size;
                        signR     <= mem_sign;
                        addrLoR   <= addr[1:0];
                        killR     <= 1'b0;
                    end
                end
                DMC_WAIT: begin
                    // A flush cannot abort the bus cycle, only the writeback.
                    if (req) killR <= 1'b1;
                    if (bus_ack) begin
                        rdataR  <= bus_rdata;
                        bus_req <= 1'b0;
                        state   <= DMC_RESP;
                    end else if (timeoutHit) begin
                        bus_req <= 1'b0;
                        state   <= DMC_IDLE;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                DMC_RESP: state <= DMC_IDLE;
                default:  state <= DMC_IDLE;
            endcase
        end
    end

    load_align u_load_align (
        .rdata    (rdataR),
        .addrLo   (addrLoR),
        .size     (sizeR),
        .sign     (signR),
        .loadData (load_data)
    );

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: directed accesses push expected bus,
// load and exception events; a negedge monitor pops and compares them.
module tb_dmem_access_ctrl;

    localparam int TIMEOUT = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_rd, mem_wr, mem_sign, req;
    logic [1:0]  mem_size;
    logic [31:0] addr, wdata;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        stall, load_valid, exc_valid;
    logic [31:0] load_data;
    logic [3:0]  exc_code;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } busItem_t;

    busItem_t    busQ[$];
    logic [31:0] loadQ[$];
    logic [3:0]  excQ[$];

    int nCompared = 0;
    int nMismatch = 0;
    int stallCnt  = 0;
    logic prevReq = 1'b0;

    dmem_access_ctrl #(.TIMEOUT_CYC(TIMEOUT), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_size   (mem_size),
        .mem_sign   (mem_sign),
        .addr       (addr),
        .wdata      (wdata),
        .req        (req),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .stall      (stall),
        .load_valid (load_valid),
        .load_data  (load_data),
        .exc_valid  (exc_valid),
        .exc_code   (exc_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (stall) stallCnt++;
    end

    // Monitor: every DUT-presented event must match the head of its queue.
    always @(negedge clk) begin : monitor
        busItem_t e;
        logic [31:0] ld;
        logic [3:0]  ec;
        if (reset) begin
            if (bus_req && !prevReq) begin
                if (busQ.size() == 0) check("bus_unexpected", 1, 0);
                else begin
                    e = busQ.pop_front();
                    check("bus_we", bus_we, e.we);
                    check("bus_addr", bus_addr, e.addr);
                    check("bus_be", bus_be, e.be);
                    check("bus_wdata", bus_wdata, e.wdata);
                end
            end
            if (load_valid) begin
                if (loadQ.size() == 0) check("load_unexpected", 1, 0);
                else begin
                    ld = loadQ.pop_front();
                    check("load_data", load_data, ld);
                end
            end
            if (exc_valid) begin
                if (excQ.size() == 0) check("exc_unexpected", 1, 0);
                else begin
                    ec = excQ.pop_front();
                    check("exc_code", exc_code, ec);
                end
            end
            if (load_valid || exc_valid) check("lv_exc_exclusive", load_valid & exc_valid, 0);
        end
        prevReq = bus_req;
    end

    task automatic clearOp();
        mem_rd = 0; mem_wr = 0; mem_size = 0; mem_sign = 0;
        addr = 0; wdata = 0; req = 0; bus_ack = 0;
    endtask

    // ackAt: WAIT cycle index carrying bus_ack (-1 = never); reqAt: WAIT cycle with req (-1 = none).
    task automatic runOp(input logic rd, input logic wr, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                         input int ackAt, input int reqAt, input logic reqIdle,
                         input logic expBus, input logic [3:0] expBe, input logic [31:0] expWdata,
                         input logic expLv, input logic [31:0] expLd, input logic [3:0] expExc,
                         input int expStall, input string tag);
        busItem_t e;
        int nWait;
        if (expBus) begin
            e.we = !rd; e.addr = {a[31:2], 2'b00}; e.be = expBe; e.wdata = expWdata;
            busQ.push_back(e);
        end
        if (expLv) loadQ.push_back(expLd);
        if (expExc != 0) excQ.push_back(expExc);

        @(posedge clk); #1;
        stallCnt = 0;
        mem_rd = rd; mem_wr = wr; mem_size = sz; mem_sign = sgn;
        addr = a; wdata = wd; req = reqIdle;
        if (expBus) begin
            nWait = (ackAt >= 0) ? ackAt + 1 : TIMEOUT;
            for (int k = 0; k < nWait; k++) begin
                @(posedge clk); #1;
                req       = (k == reqAt);
                bus_ack   = (k == ackAt);
                bus_rdata = (k == ackAt) ? rdat : $urandom;
            end
            @(posedge clk); #1;
            bus_ack = 0; req = 0;
            if (ackAt >= 0) begin
                @(posedge clk); #1;
            end
        end else begin
            @(posedge clk); #1;
        end
        clearOp();
        check({tag, "_stall_cycles"}, 64'(stallCnt), 64'(expStall));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0;
        clearOp();
        bus_rdata = 0;
        #1;
        check("rst_bus_req", bus_req, 0);
        check("rst_stall", stall, 0);
        check("rst_load_valid", load_valid, 0);
        check("rst_exc_valid", exc_valid, 0);
        check("rst_outputs", {bus_we, bus_addr, bus_be, bus_wdata}, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1;

        //     rd wr sz   sg addr          wdata         rdata         ack req ri  bus be     bus_wdata     lv ld            exc stall
        runOp(1, 0, 2'd2, 0, 32'h100,      32'h0,        32'hDEADBEEF,  1, -1, 0,  1, 4'hF, 32'h0,        1, 32'hDEADBEEF, 0, 3, "lw");
        runOp(1, 0, 2'd0, 1, 32'h103,      32'h0,        32'h80123456,  0, -1, 0,  1, 4'h8, 32'h0,        1, 32'hFFFFFF80, 0, 2, "lb");
        runOp(1, 0, 2'd0, 0, 32'h103,      32'h0,        32'h80123456,  0, -1, 0,  1, 4'h8, 32'h0,        1, 32'h00000080, 0, 2, "lbu");
        runOp(0, 1, 2'd1, 0, 32'h202,      32'h1234,     32'h0,         2, -1, 0,  1, 4'hC, 32'h12341234, 0, 32'h0,        0, 4, "sh");
        runOp(1, 0, 2'd2, 0, 32'h101,      32'h0,        32'h0,        -1, -1, 0,  0, 4'h0, 32'h0,        0, 32'h0,        4, 0, "lw_adel");
        runOp(0, 1, 2'd1, 0, 32'h3,        32'h5678,     32'h0,        -1, -1, 0,  0, 4'h0, 32'h0,        0, 32'h0,        5, 0, "sh_ades");
        runOp(1, 0, 2'd1, 1, 32'h102,      32'h0,        32'h80011234,  0, -1, 0,  1, 4'hC, 32'h0,        1, 32'hFFFF8001, 0, 2, "lh_hi");
        runOp(1, 0, 2'd1, 0, 32'h100,      32'h0,        32'h8001F00D,  0, -1, 0,  1, 4'h3, 32'h0,        1, 32'h0000F00D, 0, 2, "lhu_lo");
        runOp(1, 0, 2'd1, 1, 32'h100,      32'h0,        32'h00007FFF,  0, -1, 0,  1, 4'h3, 32'h0,        1, 32'h00007FFF, 0, 2, "lh_pos");
        runOp(0, 1, 2'd0, 0, 32'h101,      32'hFFFF12AB, 32'h0,         0, -1, 0,  1, 4'h2, 32'hABABABAB, 0, 32'h0,        0, 2, "sb");
        runOp(1, 0, 2'd0, 0, 32'h102,      32'h0,        32'h00AB0000,  0, -1, 0,  1, 4'h4, 32'h0,        1, 32'h000000AB, 0, 2, "lbu_b2");
        runOp(0, 1, 2'd2, 0, 32'h7FC,      32'h89ABCDEF, 32'h0,         3, -1, 0,  1, 4'hF, 32'h89ABCDEF, 0, 32'h0,        0, 5, "sw");
        runOp(1, 0, 2'd2, 0, 32'h104,      32'h0,        32'h12345678,  1,  0, 0,  1, 4'hF, 32'h0,        0, 32'h0,        0, 3, "lw_killed");
        runOp(1, 1, 2'd2, 0, 32'h10,       32'h55,       32'h11223344,  0, -1, 0,  1, 4'hF, 32'h55,       1, 32'h11223344, 0, 2, "rd_wr_both");
        runOp(1, 0, 2'd3, 0, 32'h20,       32'h0,        32'hCAFEF00D,  0, -1, 0,  1, 4'hF, 32'h0,        1, 32'hCAFEF00D, 0, 2, "sz3_word");
        runOp(1, 0, 2'd3, 0, 32'h22,       32'h0,        32'h0,        -1, -1, 0,  0, 4'h0, 32'h0,        0, 32'h0,        4, 0, "sz3_adel");
        runOp(1, 0, 2'd2, 0, 32'h600,      32'h0,        32'h0,        -1, -1, 1,  0, 4'h0, 32'h0,        0, 32'h0,        0, 0, "req_idle");
        runOp(1, 0, 2'd2, 0, 32'h400,      32'h0,        32'h0,        -1, -1, 0,  1, 4'hF, 32'h0,        0, 32'h0,        7, TIMEOUT, "lw_timeout");
        check("timeout_bus_req_low", bus_req, 0);

        // bus_ack while idle must be ignored
        @(posedge clk); #1;
        bus_ack = 1; bus_rdata = 32'hBAD0BAD0;
        @(posedge clk); #1;
        bus_ack = 0;
        check("idle_ack_bus_req", bus_req, 0);
        check("idle_ack_stall", stall, 0);
        @(posedge clk); #1;
        check("idle_ack_load_valid", load_valid, 0);

        // reset in WAIT drops the access immediately
        begin
            busItem_t e;
            e.we = 0; e.addr = 32'h500; e.be = 4'hF; e.wdata = 32'h0;
            busQ.push_back(e);
        end
        @(posedge clk); #1;
        mem_rd = 1; mem_size = 2'd2; addr = 32'h500;
        @(posedge clk); #1;
        @(negedge clk); #1;
        reset = 0;
        #1;
        check("wait_rst_bus_req", bus_req, 0);
        check("wait_rst_stall", stall, 0);
        check("wait_rst_outputs", {bus_we, bus_addr, bus_be, bus_wdata}, 0);
        check("wait_rst_flags", {load_valid, exc_valid, exc_code}, 0);
        check("wait_rst_load_data", load_data, 0);
        clearOp();
        @(posedge clk); #1;
        reset = 1;
        runOp(1, 0, 2'd2, 0, 32'h504, 32'h0, 32'h0BADF00D, 1, -1, 0, 1, 4'hF, 32'h0, 1, 32'h0BADF00D, 0, 3, "lw_after_rst");

        repeat (3) @(posedge clk);
        #1;
        check("busQ_drained", 64'(busQ.size()), 0);
        check("loadQ_drained", 64'(loadQ.size()), 0);
        check("excQ_drained", 64'(excQ.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
